// File: rtl/montre_de1_rtc_bcd.sv
// BCD HH:MM:SS time-of-day keeper with Avalon-MM register access and direct 7-segment drive.
// Optional alarm (ALARM register, alarm_flag, irq) is built only when MONTRE_DE1_RTC_ALARM_EN is defined.
module montre_de1_rtc_bcd #(
  parameter bit         SEG_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] RESET_HH       = 8'h00,
  parameter logic [7:0] RESET_MM       = 8'h00,
  parameter logic [7:0] RESET_SS       = 8'h00,
  parameter bit         RUN_AT_RESET   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Both nibbles must be decimal; once they are, byte compare equals BCD compare.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] maxv);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= maxv);
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [7:0]  r_hh, r_mm, r_ss;
  logic        r_run, r_disp_hm, r_tick_d;
  logic [15:0] r_readdata;
  logic [6:0]  r_hex0, r_hex1, r_hex2, r_hex3;

  logic        w_wr, w_wr_status, w_wr_ctrl, w_wr_mmss, w_wr_hh, w_wr_alarm;
  logic        w_tick_rise, w_adv;
  logic [7:0]  w_ss_n, w_mm_n, w_hh_n;
  logic        w_alarm_flag, w_alarm_ie;
  logic [15:0] w_alarm_reg;
  logic [15:0] w_rdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_status = w_wr && (address == 3'd0);
  assign w_wr_ctrl   = w_wr && (address == 3'd1);
  assign w_wr_mmss   = w_wr && (address == 3'd2);
  assign w_wr_hh     = w_wr && (address == 3'd3);
  assign w_wr_alarm  = w_wr && (address == 3'd4);

  // A time write in the same cycle as a tick swallows the tick entirely.
  assign w_tick_rise = tick_in & ~r_tick_d;
  assign w_adv       = w_tick_rise & r_run & ~w_wr_mmss & ~w_wr_hh;

  assign w_ss_n = bcd_inc(r_ss, 8'h59);
  assign w_mm_n = (r_ss == 8'h59) ? bcd_inc(r_mm, 8'h59) : r_mm;
  assign w_hh_n = (r_ss == 8'h59 && r_mm == 8'h59) ? bcd_inc(r_hh, 8'h23) : r_hh;

`ifdef MONTRE_DE1_RTC_ALARM_EN
  logic [7:0] r_ahh, r_amm;
  logic       r_alarm_flag, r_alarm_ie;
  logic       w_alarm_hit;

  assign w_alarm_hit = w_adv && (w_hh_n == r_ahh) && (w_mm_n == r_amm) && (w_ss_n == 8'h00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ahh        <= 8'h00;
      r_amm        <= 8'h00;
      r_alarm_flag <= 1'b0;
      r_alarm_ie   <= 1'b0;
    end else begin
      if (w_wr_alarm && bcd_ok(writedata[15:8], 8'h23) && bcd_ok(writedata[7:0], 8'h59)) begin
        r_ahh <= writedata[15:8];
        r_amm <= writedata[7:0];
      end
      if (w_wr_ctrl)
        r_alarm_ie <= writedata[1];
      // Set beats clear when a STATUS write lands on the alarm tick.
      if (w_alarm_hit)
        r_alarm_flag <= 1'b1;
      else if (w_wr_status)
        r_alarm_flag <= 1'b0;
    end
  end

  assign w_alarm_flag = r_alarm_flag;
  assign w_alarm_ie   = r_alarm_ie;
  assign w_alarm_reg  = {r_ahh, r_amm};
`else
  assign w_alarm_flag = 1'b0;
  assign w_alarm_ie   = 1'b0;
  assign w_alarm_reg  = 16'h0000;
`endif

  always_comb begin
    w_rdata = 16'h0000;
    case (address)
      3'd0:    w_rdata = {14'd0, r_run, w_alarm_flag};
      3'd1:    w_rdata = {13'd0, r_disp_hm, w_alarm_ie, r_run};
      3'd2:    w_rdata = {r_mm, r_ss};
      3'd3:    w_rdata = {8'h00, r_hh};
      3'd4:    w_rdata = w_alarm_reg;
      default: w_rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_d   <= 1'b0;
      r_hh       <= RESET_HH;
      r_mm       <= RESET_MM;
      r_ss       <= RESET_SS;
      r_run      <= RUN_AT_RESET;
      r_disp_hm  <= 1'b0;
      r_readdata <= 16'h0000;
    end else begin
      r_tick_d   <= tick_in;
      r_readdata <= w_rdata;
      if (w_wr_ctrl) begin
        r_run     <= writedata[0];
        r_disp_hm <= writedata[2];
      end
      if (w_wr_mmss) begin
        if (bcd_ok(writedata[15:8], 8'h59) && bcd_ok(writedata[7:0], 8'h59)) begin
          r_mm <= writedata[15:8];
          r_ss <= writedata[7:0];
        end
      end else if (w_adv) begin
        r_mm <= w_mm_n;
        r_ss <= w_ss_n;
      end
      if (w_wr_hh) begin
        if (bcd_ok(writedata[7:0], 8'h23))
          r_hh <= writedata[7:0];
      end else if (w_adv) begin
        r_hh <= w_hh_n;
      end
    end
  end

  // Display stage: segments follow the time registers one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex0 <= seg7(RESET_SS[3:0]);
      r_hex1 <= seg7(RESET_SS[7:4]);
      r_hex2 <= seg7(RESET_MM[3:0]);
      r_hex3 <= seg7(RESET_MM[7:4]);
    end else if (r_disp_hm) begin
      r_hex0 <= seg7(r_mm[3:0]);
      r_hex1 <= seg7(r_mm[7:4]);
      r_hex2 <= seg7(r_hh[3:0]);
      r_hex3 <= seg7(r_hh[7:4]);
    end else begin
      r_hex0 <= seg7(r_ss[3:0]);
      r_hex1 <= seg7(r_ss[7:4]);
      r_hex2 <= seg7(r_mm[3:0]);
      r_hex3 <= seg7(r_mm[7:4]);
    end
  end

  assign readdata = r_readdata;
  assign irq      = w_alarm_flag & w_alarm_ie;
  assign hex0     = r_hex0;
  assign hex1     = r_hex1;
  assign hex2     = r_hex2;
  assign hex3     = r_hex3;

endmodule

// File: tb/tb_montre_de1_rtc_bcd.sv
// Scoreboard bench for montre_de1_rtc_bcd; expectations follow the alarm build option of the compile.
module tb_montre_de1_rtc_bcd;

`ifdef MONTRE_DE1_RTC_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'h0000;
  logic [15:0] readdata;
  logic        irq;
  logic [6:0]  hex0, hex1, hex2, hex3;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [6:0]  segtab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  montre_de1_rtc_bcd dut (
    .clk(clk), .reset_n(reset_n), .tick_in(tick_in), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] got;
    logic [31:0] ex;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({hex3, hex2, hex1, hex0} !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
      bad++; $display("FAIL reset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, {7'h40, 7'h40, 7'h40, 7'h40});
    end
    total++;
    if (readdata !== 16'h0000) begin bad++; $display("FAIL reset_readdata got=%h exp=0000", readdata); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0001);
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0000);
    for (int i = 0; i < 3; i++) begin
      rd((i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd0, got);
      ex = exp_q.pop_front();
      if (i == 2) ex = 32'h0002;
      total++;
      if ({16'h0, got} !== ex) begin bad++; $display("FAIL reset_read%0d got=%h exp=%h", i, got, ex[15:0]); end
    end
  endtask

  task automatic test_rollover();
    logic [15:0] got;
    logic [31:0] ex;
    wr(3'd3, 16'h0023);
    wr(3'd2, 16'h5959);
    pulse_tick();
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0000);
    for (int i = 0; i < 2; i++) begin
      rd((i == 0) ? 3'd2 : 3'd3, got);
      ex = exp_q.pop_front();
      total++;
      if ({16'h0, got} !== ex) begin bad++; $display("FAIL rollover_%0d got=%h exp=%h", i, got, ex[15:0]); end
    end
  endtask

  task automatic test_reject();
    logic [15:0] got;
    logic [31:0] ex;
    logic [2:0]  ra[4] = '{3'd2, 3'd2, 3'd3, 3'd4};
    wr(3'd2, 16'h1234);
    wr(3'd3, 16'h0011);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h0011);
    exp_q.push_back(32'h0000);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: wr(3'd2, 16'h0060);
        1: wr(3'd2, 16'h1A00);
        2: wr(3'd3, 16'h0024);
        default: wr(3'd4, 16'h2400);
      endcase
      rd(ra[i], got);
      ex = exp_q.pop_front();
      total++;
      if ({16'h0, got} !== ex) begin bad++; $display("FAIL reject_%0d got=%h exp=%h", i, got, ex[15:0]); end
    end
  endtask

  task automatic test_alarm();
    logic [15:0] got;
    logic [31:0] ex;
    wr(3'd1, 16'h0003);
    wr(3'd4, 16'h0712);
    wr(3'd3, 16'h0007);
    wr(3'd2, 16'h1159);
    wr(3'd0, 16'h0000);
    exp_q.push_back(ALARM ? 32'h0003 : 32'h0001);
    exp_q.push_back(ALARM ? 32'h0712 : 32'h0000);
    exp_q.push_back(32'h0002);
    for (int i = 0; i < 3; i++) begin
      rd((i == 0) ? 3'd1 : (i == 1) ? 3'd4 : 3'd0, got);
      ex = exp_q.pop_front();
      total++;
      if ({16'h0, got} !== ex) begin bad++; $display("FAIL alarm_setup%0d got=%h exp=%h", i, got, ex[15:0]); end
    end
    tick_in = 1'b1;
    @(posedge clk); #1;
    total++;
    if (irq !== ALARM) begin bad++; $display("FAIL alarm_irq_edge got=%b exp=%b", irq, ALARM); end
    @(negedge clk);
    tick_in = 1'b0;
    rd(3'd2, got);
    total++;
    if (got !== 16'h1200) begin bad++; $display("FAIL alarm_time got=%h exp=1200", got); end
    wr(3'd0, 16'h0000);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL alarm_irq_clear got=%b exp=0", irq); end
    // Interrupts masked; STATUS write collides with the alarm tick.
    wr(3'd1, 16'h0001);
    wr(3'd2, 16'h1159);
    tick_in = 1'b1; address = 3'd0; writedata = 16'h0000; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL alarm_masked_irq got=%b exp=0", irq); end
    exp_q.push_back(ALARM ? 32'h0003 : 32'h0002);
    rd(3'd0, got);
    ex = exp_q.pop_front();
    total++;
    if ({16'h0, got} !== ex) begin bad++; $display("FAIL alarm_masked_status got=%h exp=%h", got, ex[15:0]); end
    wr(3'd0, 16'h0000);
  endtask

  task automatic test_simultaneous();
    logic [15:0] got;
    logic [31:0] ex;
    wr(3'd2, 16'h2959);
    tick_in = 1'b1; address = 3'd2; writedata = 16'h3000; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h3000);
    rd(3'd2, got);
    ex = exp_q.pop_front();
    total++;
    if ({16'h0, got} !== ex) begin bad++; $display("FAIL tick_vs_write got=%h exp=%h", got, ex[15:0]); end
    tick_in = 1'b1;
    repeat (100) @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'h3001);
    rd(3'd2, got);
    ex = exp_q.pop_front();
    total++;
    if ({16'h0, got} !== ex) begin bad++; $display("FAIL tick_held got=%h exp=%h", got, ex[15:0]); end
    wr(3'd1, 16'h0000);
    repeat (5) pulse_tick();
    exp_q.push_back(32'h3001);
    rd(3'd2, got);
    ex = exp_q.pop_front();
    total++;
    if ({16'h0, got} !== ex) begin bad++; $display("FAIL run_off got=%h exp=%h", got, ex[15:0]); end
    wr(3'd1, 16'h0001);
  endtask

  task automatic test_display();
    logic [27:0] ex;
    wr(3'd3, 16'h0012);
    wr(3'd2, 16'h3456);
    wr(3'd1, 16'h0001);
    exp_q.push_back({4'h0, segtab[3], segtab[4], segtab[5], segtab[6]});
    exp_q.push_back({4'h0, segtab[3], segtab[4], segtab[5], segtab[6]});
    exp_q.push_back({4'h0, segtab[1], segtab[2], segtab[3], segtab[4]});
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wr(3'd1, 16'h0005);
      if (i == 2) @(negedge clk);
      ex = exp_q.pop_front();
      total++;
      if ({hex3, hex2, hex1, hex0} !== ex) begin
        bad++; $display("FAIL display_%0d got=%h exp=%h", i, {hex3, hex2, hex1, hex0}, ex);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got;
    logic [31:0] ex;
    #3 reset_n = 1'b0;
    #1;
    total++;
    if ({hex3, hex2, hex1, hex0, readdata} !== {7'h40, 7'h40, 7'h40, 7'h40, 16'h0000}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {hex3, hex2, hex1, hex0, readdata},
                      {7'h40, 7'h40, 7'h40, 7'h40, 16'h0000});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0000);
    exp_q.push_back(32'h0001);
    for (int i = 0; i < 3; i++) begin
      rd((i == 0) ? 3'd2 : (i == 1) ? 3'd3 : 3'd1, got);
      ex = exp_q.pop_front();
      total++;
      if ({16'h0, got} !== ex) begin bad++; $display("FAIL async_reset_read%0d got=%h exp=%h", i, got, ex[15:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_reject();
    test_alarm();
    test_simultaneous();
    test_display();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/montre_de1_rtc_bcd.md
# montre_de1_rtc_bcd

BCD time-of-day keeper for the Montre DE1 watch system. It sits directly downstream of the interval timer: the timer's 1 Hz interrupt line drives `tick_in`, and each rising edge advances an HH:MM:SS counter. The block exposes a 16-bit Avalon-MM slave for setting and reading the time and for alarm control. It drives the four DE1 seven-segment displays directly, so the display updates with no CPU involvement.

## Interface
Parameters:
- `SEG_ACTIVE_LOW`, default 1: 1 = segment outputs are active-low (DE1 board); 0 = active-high.
- `RESET_HH`, default 8'h00: BCD hours value loaded at reset.
- `RESET_MM`, default 8'h00: BCD minutes value loaded at reset.
- `RESET_SS`, default 8'h00: BCD seconds value loaded at reset.
- `RUN_AT_RESET`, default 1: reset value of CONTROL.run.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `tick_in`  in  1  timer irq, synchronous to `clk`; each rising edge = one second.
- `address`  in  3  Avalon word address.
- `chipselect`  in  1  Avalon select.
- `write_n`  in  1  Avalon write strobe, active-low.
- `writedata`  in  16  Avalon write data.
- `readdata`  out  16  Avalon read data, registered.
- `irq`  out  1  alarm interrupt.
- `hex0`  out  7  seven-segment digit 0 (rightmost), bit0 = segment a … bit6 = segment g.
- `hex1`  out  7  seven-segment digit 1.
- `hex2`  out  7  seven-segment digit 2.
- `hex3`  out  7  seven-segment digit 3.

## Operation
Register map. A write occurs when `chipselect` = 1 and `write_n` = 0.
- Address 0, STATUS:
  - bit0 = `alarm_flag`, bit1 = run.
  - Any write clears `alarm_flag`.
- Address 1, CONTROL (read/write bits [2:0]):
  - bit0 = run.
  - bit1 = alarm_ie.
  - bit2 = disp_hm: 1 shows HH:MM, 0 shows MM:SS.
- Address 2, MMSS: {MM[15:8], SS[7:0]}, BCD.
- Address 3, HH: {8'h00, HH[7:0]}, BCD.
- Address 4, ALARM: {AHH[15:8], AMM[7:0]}, BCD.
- Addresses 5–7: read 0; writes are ignored.

Tick handling:
- Edge detection: `tick_rise = tick_in & ~tick_d`, where `tick_d` is `tick_in` registered.
- If `tick_rise` = 1 and run = 1, the time advances by one second on the same edge.
- If run = 0, ticks are dropped; they are not queued.
- Carry chain:
  - SS 59 → 00 increments MM.
  - MM 59 → 00 increments HH.
  - HH 23 → 00.
  - 23:59:59 → 00:00:00 on a single tick.
  - Within each digit pair, the low nibble wraps 9 → 0 and carries into the high nibble.
  - Binary values in the range A–F never appear in any time register.

Write validation:
- A write to MMSS, HH or ALARM is rejected unless every nibble is 0–9, SS ≤ 59, MM ≤ 59 and HH ≤ 23.
- A rejected write leaves the register unchanged.
- No error is reported for a rejected write.

Alarm:
- `alarm_flag` is set on a tick whose result time equals AHH:AMM:00.
- Writes that produce a matching time never set the flag.
- `irq = alarm_flag & alarm_ie`.

Display:
- disp_hm = 0: `hex3..hex0` = M1 M0 S1 S0.
- disp_hm = 1: `hex3..hex0` = H1 H0 M1 M0.
- Encoding is standard gfedcba. When `SEG_ACTIVE_LOW` = 1, every pattern is inverted.
- Active-low values: "0" = 7'h40, "1" = 7'h79, "5" = 7'h12, "9" = 7'h10.

## Timing
Reset values:
- `readdata` = 0, `irq` = 0, `alarm_flag` = 0, `tick_d` = 0.
- Time = `RESET_HH`:`RESET_MM`:`RESET_SS`.
- ALARM = 00:00.
- CONTROL = {0, 0, `RUN_AT_RESET`}.
- `hex*` show the reset time in MM:SS mode.

Latencies:
- Read: one cycle. `readdata` at edge N+1 reflects the address and register contents at edge N.
- Tick: the time register updates on the first edge at which `tick_in` = 1, provided `tick_in` was 0 at the previous edge. `hex*` reflect the new time one edge later.
- Alarm: `alarm_flag` and `irq` assert on the same edge as the matching time update.

Simultaneous events:
- Write to MMSS or HH in the same cycle as `tick_rise`: the write wins, and the tick is discarded for all time fields.
- STATUS write in the same cycle as an alarm-setting tick: the flag is set, because set has priority over clear.
- `tick_in` held high: exactly one increment.

Reset mid-operation:
- Asserting `reset_n` in any cycle returns all state to the reset values immediately, asynchronously.

## Configuration
- Macro: `MONTRE_DE1_RTC_ALARM_EN`.
- Defined:
  - The alarm feature is present as described above.
- Undefined:
  - The ALARM register and `alarm_flag` are removed.
  - Address 4 reads 0, and writes to it are ignored.
  - STATUS bit0 reads 0, and CONTROL bit1 reads 0.
  - `irq` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Reset with default parameters: `hex3..hex0` = 7'h40 ×4, `readdata` = 0, `irq` = 0. Read address 1 → 16'h0001.
- Write HH = 16'h0023 and MMSS = 16'h5959, then pulse `tick_in`: MMSS reads 16'h0000, HH reads 16'h0000.
- Write MMSS = 16'h0060, then 16'h1A00: both rejected, and the previous value reads back. Write HH = 16'h0024: rejected.
- ALARM = 16'h0712, CONTROL = 16'h0003, time 07:11:59, one tick: `irq` = 1 on the update edge. Write STATUS → `irq` = 0 next cycle. Repeat with alarm_ie = 0: `irq` stays 0 while STATUS bit0 = 1.
- Tick coincident with MMSS write of 16'h3000: MMSS reads 16'h3000, not 16'h3001. `tick_in` held high for 100 cycles: exactly one increment. run = 0 with 5 ticks: time unchanged.
- Display at time 12:34:56: disp_hm = 0 gives hex digits 3,4,5,6. disp_hm = 1 gives 1,2,3,4, one cycle after the CONTROL write.
